tt_uart: RTL and testbench
==========================

# tt_uart

Full-duplex UART peripheral for the TinyTapeout-style pin wrapper: transmits a byte from `uio_in`, receives a byte on `ui_in[0]` into `uio_out`, with runtime-selectable 5–8 data bits, optional even/odd parity and 1 or 2 stop bits. Both directions share a 16x-oversampling baud tick. It sits directly at the chip top level; all control and status are on the standard pin buses.

## Interface
- `CLK_FREQ`, 100_000_000, clock frequency in Hz (internal baud generator only)
- `BAUD_RATE`, 115_200, baud rate (internal baud generator only)

- `clk` in 1: the single clock
- `rst` in 1: synchronous, active-high reset
- `ena` in 1: design-enable; ignored
- `ui_in` in 8:
  - [0] rx
  - [1] tx_start (level)
  - [2] baud16_tick
  - [4:3] data_bits (00=5, 01=6, 10=7, 11=8)
  - [5] parity_type (1=even, 0=odd)
  - [6] parity_disable
  - [7] stop_bits (0=1, 1=2)
- `uo_out` out 8:
  - [0] tx
  - [1] tx_busy
  - [2] rx_ready
  - [3] rx_error (parity OR frame)
  - [4] parity_err
  - [5] frame_err
  - [7:6] 0
- `uio_in` in 8: TX data byte
- `uio_out` out 8: last received byte, right-justified, unused MSBs 0
- `uio_oe` out 8: constant 8'hFF

## Operation
- Tick: one-`clk` enable, 16 per bit period; all bit timing counts ticks only.
- Reset values:
  - `tx`=1
  - `tx_busy`=0
  - `rx_ready`=0
  - all error flags 0
  - `uio_out`=0
  - both FSMs IDLE
- TX FSM: IDLE→START→DATA→PARITY(if enabled)→STOP→IDLE.
  - In IDLE with tx_start=1: latch `uio_in` and ui_in[7:3]; go to START.
  - Each state holds for 16 ticks. Data goes out LSB first, count per data_bits.
  - Parity bit: even → total ones including parity is even; odd → total ones is odd.
  - STOP lasts 16 or 32 ticks.
  - tx_start while not IDLE is ignored. If tx_start is still high on return to IDLE, a new frame starts.
- RX path:
  - rx passes through a 2-flop synchronizer.
  - RX FSM: IDLE→START→DATA→PARITY(opt)→STOP→IDLE.
  - Falling edge in IDLE: latch config, clear rx_ready and errors, enter START.
  - START: at tick 8 sample rx. If high (glitch), return to IDLE with no flags set.
  - Each later bit is sampled after 16 more ticks (mid-bit) and shifted in LSB first.
  - parity_err is set if the sampled parity mismatches the computed parity.
  - frame_err is set if any sampled stop bit is 0.
  - At the last stop-bit sample: write data to `uio_out`, set rx_ready, set the error flags.
  - Return to IDLE immediately after the last stop-bit sample, so RX can catch a start bit during the remainder of the stop bit.
  - rx_ready and the flags hold until the next start-bit detection.
- `uio_out` holds the previous byte until a new frame completes.

## Timing
- tx_start sampled at a `clk` edge: `tx_busy`=1 and `tx`=0 from the next edge.
- Frame length in ticks: 16 × (1 + N + P + S).
- `tx_busy` falls on the edge after the final stop tick.
- RX complete: `rx_ready` rises on the `clk` edge after the final stop-bit mid-sample tick.
- Sample latency:
  - 2 cycles of synchronizer delay
  - start-bit sample 8 ticks after edge detection
- Mid-frame reset: `rst` aborts both FSMs on the next edge and restores reset values.
- Config changes mid-frame have no effect until the next frame.
- TX and RX run fully independently and concurrently.

## Configuration
- `INTERNAL_BAUD_EN`
  - Defined: an internal counter produces baud16_tick every CLK_FREQ/(BAUD_RATE×16) cycles (54 at defaults), counter cleared by rst; ui_in[2] ignored.
  - Undefined: ui_in[2] is the tick; no counter.

## Test plan
- 8N1 TX, `uio_in`=8'hA5, tx_start 2 cycles:
  - tx_busy rises next cycle.
  - tx waveform is 0,1,0,1,0,0,1,0,1,1, each bit 16 ticks.
  - tx_busy falls after 160 ticks.
- 8N1 RX of 0x5A at the baud period:
  - rx_ready=1, `uio_out`=8'h5A, rx_error=0.
  - Flags held until the next start bit.
- 8E1 RX of 0x00 with parity bit 1:
  - rx_ready=1, parity_err=1, rx_error=1.
  - The same frame with parity 0 gives no error.
- 8N1 RX of 0x55 with stop bit driven 0:
  - rx_ready=1, frame_err=1, rx_error=1, `uio_out`=8'h55.
- Configuration coverage:
  - 5O2 TX of 8'h1F: 5 data bits, parity bit 0, 32-tick stop.
  - 6-bit RX of 0x3F gives `uio_out`=8'h3F.
- Robustness:
  - A rx low pulse shorter than 8 ticks sets no flags.
  - Asserting rst mid-TX forces tx=1 and tx_busy=0 on the next edge.
  - A second tx_start while busy is ignored.

Source files
------------

// File: rtl/tt_uart.sv
// -----------------------------------------------------------------------------
// tt_uart - full-duplex UART for the TinyTapeout pin wrapper.
//
// Transmits the byte on uio_in and receives a byte on ui_in[0] into uio_out.
// Frame format (5-8 data bits, even/odd/no parity, 1 or 2 stop bits) is
// selected at runtime from ui_in[7:3] and latched at the start of each frame,
// independently for TX and RX. All bit timing counts a 16x oversampling tick.
//
// Ports
//   clk      : single clock
//   rst      : synchronous, active-high reset
//   ena      : design enable (ignored)
//   ui_in    : [0] rx, [1] tx_start (level), [2] baud16_tick,
//              [4:3] data_bits (00=5..11=8), [5] parity_type (1=even),
//              [6] parity_disable, [7] stop_bits (0=1, 1=2)
//   uo_out   : [0] tx, [1] tx_busy, [2] rx_ready, [3] rx_error,
//              [4] parity_err, [5] frame_err, [7:6] 0
//   uio_in   : TX data byte
//   uio_out  : last received byte, right-justified, unused MSBs 0
//   uio_oe   : constant 8'hFF
//
// Build option
//   INTERNAL_BAUD_EN : when defined, an internal divider generates the tick
//                      every CLK_FREQ/(BAUD_RATE*16) cycles and ui_in[2] is
//                      ignored; otherwise ui_in[2] is the tick.
// -----------------------------------------------------------------------------
module tt_uart #(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned BAUD_RATE = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    // Field order matches ui_in[7:3] so the pins cast straight onto it.
    typedef struct packed {
        logic       stop2;
        logic       parity_dis;
        logic       parity_even;
        logic [1:0] data_bits;
    } cfg_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    localparam int unsigned BAUD_DIV = CLK_FREQ / (BAUD_RATE * 16);

    logic unused_ena;
    assign unused_ena = ena;

    cfg_t cfg_in;
    assign cfg_in = cfg_t'(ui_in[7:3]);

    // Keeps only the configured number of data bits (5..8).
    function automatic logic [7:0] data_mask(input logic [1:0] data_bits);
        return 8'hFF >> (2'd3 - data_bits);
    endfunction

    // -------------------------------------------------------------------------
    // Baud tick
    // -------------------------------------------------------------------------
    logic baud_tick;

`ifdef INTERNAL_BAUD_EN
    localparam int unsigned BAUD_CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    logic [BAUD_CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic                  unused_tick_pin;

    assign unused_tick_pin = ui_in[2];
    assign baud_tick       = (baud_cnt_q == BAUD_CNT_W'(BAUD_DIV - 1));

    always_comb begin
        baud_cnt_d = baud_tick ? '0 : baud_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt_q <= '0;
        end else begin
            baud_cnt_q <= baud_cnt_d;
        end
    end
`else
    logic [31:0] unused_baud_div;

    assign unused_baud_div = BAUD_DIV;
    assign baud_tick       = ui_in[2];
`endif

    // -------------------------------------------------------------------------
    // Transmitter
    // -------------------------------------------------------------------------
    state_e     tx_state_q, tx_state_d;
    logic [4:0] tx_tick_q, tx_tick_d;
    logic [2:0] tx_bit_q, tx_bit_d;
    logic [7:0] tx_data_q, tx_data_d;
    cfg_t       tx_cfg_q, tx_cfg_d;
    logic [4:0] tx_last_tick;
    logic       tx_bit_end;
    logic       tx_par;
    logic       tx_out;
    logic       tx_busy;

    // Latched data is already masked, so the reduction covers only data bits.
    assign tx_par       = (^tx_data_q) ^ ~tx_cfg_q.parity_even;
    assign tx_last_tick = (tx_state_q == S_STOP && tx_cfg_q.stop2) ? 5'd31 : 5'd15;
    assign tx_bit_end   = baud_tick && (tx_tick_q == tx_last_tick);
    assign tx_busy      = (tx_state_q != S_IDLE);

    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // left one unassigned would infer a latch.
        tx_state_d = tx_state_q;
        tx_tick_d  = baud_tick ? tx_tick_q + 5'd1 : tx_tick_q;
        tx_bit_d   = tx_bit_q;
        tx_data_d  = tx_data_q;
        tx_cfg_d   = tx_cfg_q;
        tx_out     = 1'b1;

        unique case (tx_state_q)
            S_IDLE: begin
                tx_tick_d = '0;
                if (ui_in[1]) begin
                    tx_state_d = S_START;
                    tx_cfg_d   = cfg_in;
                    tx_data_d  = uio_in & data_mask(cfg_in.data_bits);
                    tx_bit_d   = '0;
                end
            end
            S_START: begin
                tx_out = 1'b0;
                if (tx_bit_end) begin
                    tx_state_d = S_DATA;
                    tx_tick_d  = '0;
                end
            end
            S_DATA: begin
                tx_out = tx_data_q[tx_bit_q];
                if (tx_bit_end) begin
                    tx_tick_d = '0;
                    // {1'b1, data_bits} is the index of the last data bit.
                    if (tx_bit_q == {1'b1, tx_cfg_q.data_bits}) begin
                        tx_state_d = tx_cfg_q.parity_dis ? S_STOP : S_PARITY;
                        tx_bit_d   = '0;
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                tx_out = tx_par;
                if (tx_bit_end) begin
                    tx_state_d = S_STOP;
                    tx_tick_d  = '0;
                end
            end
            S_STOP: begin
                if (tx_bit_end) begin
                    tx_state_d = S_IDLE;
                    tx_tick_d  = '0;
                end
            end
            default: begin
                tx_state_d = S_IDLE;
                tx_tick_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            tx_state_q <= S_IDLE;
            tx_tick_q  <= '0;
            tx_bit_q   <= '0;
            tx_data_q  <= '0;
            tx_cfg_q   <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_tick_q  <= tx_tick_d;
            tx_bit_q   <= tx_bit_d;
            tx_data_q  <= tx_data_d;
            tx_cfg_q   <= tx_cfg_d;
        end
    end

    // -------------------------------------------------------------------------
    // Receiver
    // -------------------------------------------------------------------------
    logic       rx_meta_q, rx_sync_q, rx_prev_q;
    state_e     rx_state_q, rx_state_d;
    logic [3:0] rx_tick_q, rx_tick_d;
    logic [2:0] rx_bit_q, rx_bit_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    cfg_t       rx_cfg_q, rx_cfg_d;
    logic       rx_par_bad_q, rx_par_bad_d;
    logic       rx_stop_bad_q, rx_stop_bad_d;
    logic       rx_stop2nd_q, rx_stop2nd_d;
    logic       rx_ready_q, rx_ready_d;
    logic       parity_err_q, parity_err_d;
    logic       frame_err_q, frame_err_d;
    logic [7:0] rx_byte_q, rx_byte_d;
    logic       rx_sample;
    logic       rx_stop_bad_now;

    // Start bit is checked at its middle (8 ticks); later bits 16 ticks apart.
    assign rx_sample = baud_tick &&
                       (rx_tick_q == ((rx_state_q == S_START) ? 4'd7 : 4'd15));
    assign rx_stop_bad_now = rx_stop_bad_q | ~rx_sync_q;

    always_comb begin
        rx_state_d    = rx_state_q;
        rx_tick_d     = baud_tick ? rx_tick_q + 4'd1 : rx_tick_q;
        rx_bit_d      = rx_bit_q;
        rx_shift_d    = rx_shift_q;
        rx_cfg_d      = rx_cfg_q;
        rx_par_bad_d  = rx_par_bad_q;
        rx_stop_bad_d = rx_stop_bad_q;
        rx_stop2nd_d  = rx_stop2nd_q;
        rx_ready_d    = rx_ready_q;
        parity_err_d  = parity_err_q;
        frame_err_d   = frame_err_q;
        rx_byte_d     = rx_byte_q;

        unique case (rx_state_q)
            S_IDLE: begin
                rx_tick_d = '0;
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d    = S_START;
                    rx_cfg_d      = cfg_in;
                    rx_bit_d      = '0;
                    rx_shift_d    = '0;
                    rx_par_bad_d  = 1'b0;
                    rx_stop_bad_d = 1'b0;
                    rx_stop2nd_d  = 1'b0;
                    rx_ready_d    = 1'b0;
                    parity_err_d  = 1'b0;
                    frame_err_d   = 1'b0;
                end
            end
            S_START: begin
                if (rx_sample) begin
                    rx_tick_d  = '0;
                    // A line already back high was a glitch, not a start bit.
                    rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (rx_sample) begin
                    rx_tick_d            = '0;
                    rx_shift_d[rx_bit_q] = rx_sync_q;
                    if (rx_bit_q == {1'b1, rx_cfg_q.data_bits}) begin
                        rx_state_d = rx_cfg_q.parity_dis ? S_STOP : S_PARITY;
                        rx_bit_d   = '0;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (rx_sample) begin
                    rx_tick_d    = '0;
                    rx_par_bad_d = rx_sync_q != ((^rx_shift_q) ^ ~rx_cfg_q.parity_even);
                    rx_state_d   = S_STOP;
                end
            end
            S_STOP: begin
                if (rx_sample) begin
                    rx_tick_d = '0;
                    if (rx_cfg_q.stop2 && !rx_stop2nd_q) begin
                        rx_stop2nd_d  = 1'b1;
                        rx_stop_bad_d = rx_stop_bad_now;
                    end else begin
                        // Leave mid-stop so a start bit right after is caught.
                        rx_state_d   = S_IDLE;
                        rx_byte_d    = rx_shift_q;
                        rx_ready_d   = 1'b1;
                        parity_err_d = rx_par_bad_q;
                        frame_err_d  = rx_stop_bad_now;
                    end
                end
            end
            default: begin
                rx_state_d = S_IDLE;
                rx_tick_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // Synchronizer resets to the idle line level so no false edge.
            rx_meta_q     <= 1'b1;
            rx_sync_q     <= 1'b1;
            rx_prev_q     <= 1'b1;
            rx_state_q    <= S_IDLE;
            rx_tick_q     <= '0;
            rx_bit_q      <= '0;
            rx_shift_q    <= '0;
            rx_cfg_q      <= '0;
            rx_par_bad_q  <= 1'b0;
            rx_stop_bad_q <= 1'b0;
            rx_stop2nd_q  <= 1'b0;
            rx_ready_q    <= 1'b0;
            parity_err_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            rx_byte_q     <= '0;
        end else begin
            rx_meta_q     <= ui_in[0];
            rx_sync_q     <= rx_meta_q;
            rx_prev_q     <= rx_sync_q;
            rx_state_q    <= rx_state_d;
            rx_tick_q     <= rx_tick_d;
            rx_bit_q      <= rx_bit_d;
            rx_shift_q    <= rx_shift_d;
            rx_cfg_q      <= rx_cfg_d;
            rx_par_bad_q  <= rx_par_bad_d;
            rx_stop_bad_q <= rx_stop_bad_d;
            rx_stop2nd_q  <= rx_stop2nd_d;
            rx_ready_q    <= rx_ready_d;
            parity_err_q  <= parity_err_d;
            frame_err_q   <= frame_err_d;
            rx_byte_q     <= rx_byte_d;
        end
    end

    // -------------------------------------------------------------------------
    // Pin mapping
    // -------------------------------------------------------------------------
    assign uo_out  = {2'b00, frame_err_q, parity_err_q, parity_err_q | frame_err_q,
                      rx_ready_q, tx_busy, tx_out};
    assign uio_out = rx_byte_q;
    assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_uart.sv
// -----------------------------------------------------------------------------
// tb_tt_uart - self-checking bench for tt_uart (external tick build).
//
// A frame-level model predicts the TX line as a list of bits, each lasting 16
// ticks from the edge that accepted tx_start, and the RX status as the result
// of the last complete frame. One compare process checks the outputs against
// the model on every falling clock edge; directed tests add hand-computed
// literal checks.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tt_uart;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic       rx = 1'b1;
    logic       tx_start = 1'b0;
    logic       tick = 1'b0;
    logic [4:0] cfg = 5'b0;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 1'b0;

    assign ui_in = {cfg, tick, tx_start, rx};

    tt_uart dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    // One tick every fourth clock, changed on the falling edge.
    initial begin
        int div = 0;
        forever begin
            @(negedge clk);
            div  = (div + 1) % 4;
            tick = (div == 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] mk_cfg(input int nbits, input bit par_en,
                                          input bit even, input bit stop2);
        return {stop2, ~par_en, even, 2'(nbits - 5)};
    endfunction

    // ---------------------------------------------------------------------
    // Model
    // ---------------------------------------------------------------------
    bit         m_bits[12];
    int         m_nbits  = 0;
    int         m_t      = 0;
    bit         m_active = 1'b0;
    bit         rx_chk_en = 1'b1;
    logic [7:0] exp_uio  = 8'h00;
    bit         exp_rdy  = 1'b0;
    bit         exp_perr = 1'b0;
    bit         exp_ferr = 1'b0;

    function automatic bit parity_of(input logic [7:0] d, input int nbits, input bit even);
        int ones = 0;
        for (int i = 0; i < nbits; i++) ones += int'(d[i]);
        return even ? bit'(ones % 2) : bit'(1 - ones % 2);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_active = 1'b0;
            exp_uio  = 8'h00;
            exp_rdy  = 1'b0;
            exp_perr = 1'b0;
            exp_ferr = 1'b0;
        end else if (!m_active) begin
            if (tx_start) begin
                int n;
                n = 5 + int'(cfg[1:0]);
                m_nbits = 0;
                m_bits[m_nbits++] = 1'b0;
                for (int i = 0; i < n; i++) m_bits[m_nbits++] = uio_in[i];
                if (!cfg[3]) m_bits[m_nbits++] = parity_of(uio_in, n, cfg[2]);
                m_bits[m_nbits++] = 1'b1;
                if (cfg[4]) m_bits[m_nbits++] = 1'b1;
                m_t      = 0;
                m_active = 1'b1;
            end
        end else if (tick) begin
            m_t++;
            if (m_t == 16 * m_nbits) m_active = 1'b0;
        end
    end

    // Single compare process.
    always @(negedge clk) begin
        if (chk_on) begin
            check("tx", uo_out[0], m_active ? m_bits[m_t / 16] : 1'b1);
            check("tx_busy", uo_out[1], m_active);
            check("uio_oe", uio_oe, 8'hFF);
            check("uo_out_hi", uo_out[7:6], 2'b00);
            if (rx_chk_en) begin
                check("rx_ready", uo_out[2], exp_rdy);
                check("rx_error", uo_out[3], exp_perr | exp_ferr);
                check("parity_err", uo_out[4], exp_perr);
                check("frame_err", uo_out[5], exp_ferr);
                check("uio_out", uio_out, exp_uio);
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers
    // ---------------------------------------------------------------------
    // Advance until n tick-sampling edges have been counted since a frame start.
    task automatic advance(inout int n, input int target);
        while (n < target) begin
            @(posedge clk);
            if (tick) n++;
        end
    endtask

    task automatic wait_ticks(input int k);
        int n = 0;
        advance(n, k);
    endtask

    task automatic drive_bit(input bit b);
        @(negedge clk);
        rx = b;
        wait_ticks(16);
    endtask

    task automatic rx_frame(input logic [7:0] d, input int nbits, input bit par_en,
                            input bit even, input bit par_flip, input bit stop_val,
                            input bit stop2);
        bit par;
        @(negedge clk);
        rx_chk_en = 1'b0;
        cfg = mk_cfg(nbits, par_en, even, stop2);
        par = parity_of(d, nbits, even) ^ par_flip;
        drive_bit(1'b0);
        #1 check("rx_ready_cleared", uo_out[2], 1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(d[i]);
        if (par_en) drive_bit(par);
        drive_bit(stop_val);
        if (stop2) drive_bit(1'b1);
        @(negedge clk);
        rx = 1'b1;
        exp_uio   = d & (8'hFF >> (8 - nbits));
        exp_rdy   = 1'b1;
        exp_perr  = par_en & par_flip;
        exp_ferr  = ~stop_val;
        rx_chk_en = 1'b1;
        // Idle gap: compare process confirms the flags hold.
        wait_ticks(24);
    endtask

    // ---------------------------------------------------------------------
    // Tests
    // ---------------------------------------------------------------------
    initial begin
        int n;
        logic [9:0] wave_exp;
        logic [9:0] wave_got;

        repeat (3) @(posedge clk);
        #1;
        chk_on = 1'b1;
        check("reset_uo_out", uo_out, 8'h01);
        check("reset_uio_out", uio_out, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        wait_ticks(4);

        // 8N1 TX of A5, tx_start held two cycles.
        @(negedge clk);
        cfg = mk_cfg(8, 1'b0, 1'b0, 1'b0);
        uio_in = 8'hA5;
        tx_start = 1'b1;
        @(posedge clk);
        #1;
        check("tx_busy_rise", uo_out[1], 1'b1);
        check("tx_start_low", uo_out[0], 1'b0);
        wave_exp = 10'b1101001010;
        for (int i = 0; i < 10; i++) wave_got[i] = m_bits[i];
        check("model_a5_len", m_nbits, 10);
        check("model_a5_wave", wave_got, wave_exp);
        n = 0;
        @(posedge clk);
        if (tick) n++;
        @(negedge clk);
        tx_start = 1'b0;
        uio_in = 8'h3C;
        for (int b = 0; b < 10; b++) begin
            advance(n, 16 * b + 8);
            #1 check("a5_mid_bit", uo_out[0], wave_exp[b]);
        end
        advance(n, 159);
        #1 check("a5_busy_159", uo_out[1], 1'b1);
        advance(n, 160);
        #1;
        check("a5_busy_fall", uo_out[1], 1'b0);
        check("a5_idle_tx", uo_out[0], 1'b1);
        wait_ticks(8);

        // 5O2 TX of 1F with an ignored tx_start mid-frame.
        @(negedge clk);
        cfg = mk_cfg(5, 1'b1, 1'b0, 1'b1);
        uio_in = 8'h1F;
        tx_start = 1'b1;
        @(posedge clk);
        #1;
        check("model_5o2_len", m_nbits, 9);
        check("model_5o2_par", m_bits[6], 1'b0);
        @(negedge clk);
        tx_start = 1'b0;
        n = 0;
        advance(n, 40);
        @(negedge clk);
        uio_in = 8'h00;
        tx_start = 1'b1;
        repeat (3) @(negedge clk);
        tx_start = 1'b0;
        advance(n, 104);
        #1 check("5o2_parity_bit", uo_out[0], 1'b0);
        advance(n, 140);
        #1;
        check("5o2_stop2_busy", uo_out[1], 1'b1);
        check("5o2_stop2_tx", uo_out[0], 1'b1);
        advance(n, 143);
        #1 check("5o2_busy_143", uo_out[1], 1'b1);
        advance(n, 144);
        #1 check("5o2_busy_fall", uo_out[1], 1'b0);
        wait_ticks(8);

        // RX frames.
        rx_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("rx_5a_data", uio_out, 8'h5A);
        check("rx_5a_flags", uo_out[5:2], 4'b0001);

        rx_frame(8'h00, 8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check("rx_8e1_bad_flags", uo_out[5:2], 4'b0111);

        rx_frame(8'h00, 8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        check("rx_8e1_good_flags", uo_out[5:2], 4'b0001);

        rx_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rx_frame_err_flags", uo_out[5:2], 4'b1011);
        check("rx_frame_err_data", uio_out, 8'h55);

        rx_frame(8'h3F, 6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("rx_6bit_data", uio_out, 8'h3F);

        rx_frame(8'hC3, 7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        check("rx_7o2_data", uio_out, 8'h43);

        // Short low glitch: detection clears the flags, nothing else changes.
        @(negedge clk);
        rx_chk_en = 1'b0;
        rx = 1'b0;
        wait_ticks(5);
        @(negedge clk);
        rx = 1'b1;
        wait_ticks(20);
        #1;
        check("glitch_flags", uo_out[5:2], 4'b0000);
        check("glitch_data_held", uio_out, 8'h43);
        exp_rdy   = 1'b0;
        exp_perr  = 1'b0;
        exp_ferr  = 1'b0;
        rx_chk_en = 1'b1;
        wait_ticks(4);

        // Reset in the middle of a TX frame.
        @(negedge clk);
        cfg = mk_cfg(8, 1'b0, 1'b0, 1'b0);
        uio_in = 8'h00;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        wait_ticks(50);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_tx", uo_out[0], 1'b1);
        check("rst_busy", uo_out[1], 1'b0);
        check("rst_uio_out", uio_out, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        wait_ticks(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout reached at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
